// File: rtl/pong_engine.sv
// Tick-paced pong game state: ball, paddles, scores and game-phase FSM,
// plus a registered readout mux for the top level.
//
// state | meaning
// IDLE  | waiting for start, ball parked at centre
// SERVE | ball parked at centre, serve delay counting down
// PLAY  | ball moving, wall/paddle bounces and scoring active
// OVER  | a player reached WIN_SCORE, everything frozen until start
module pong_engine #(
    parameter int COORD_W     = 8,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int PADDLE_HALF = 4,
    parameter int TICK_DIV    = 4,
    parameter int SERVE_DELAY = 16,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               left_up,
    input  logic               left_down,
    input  logic               right_up,
    input  logic               right_down,
    input  logic               start,
    input  logic [2:0]         sel,
    output logic [COORD_W-1:0] data_out,
    output logic               tick,
    output logic               point_left,
    output logic               point_right,
    output logic [1:0]         state
);

    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SERVE_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

    localparam logic [COORD_W-1:0] ONE       = COORD_W'(1);
    localparam logic [COORD_W-1:0] X_MID     = COORD_W'(SCREEN_W / 2);
    localparam logic [COORD_W-1:0] Y_MID     = COORD_W'(SCREEN_H / 2);
    localparam logic [COORD_W-1:0] X_MAX     = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX     = COORD_W'(SCREEN_H - 1);
    localparam logic [COORD_W-1:0] X_LHIT    = COORD_W'(1);
    localparam logic [COORD_W-1:0] X_LBOUNCE = COORD_W'(2);
    localparam logic [COORD_W-1:0] X_RHIT    = COORD_W'(SCREEN_W - 2);
    localparam logic [COORD_W-1:0] X_RBOUNCE = COORD_W'(SCREEN_W - 3);
    localparam logic [COORD_W-1:0] PAD_MIN   = COORD_W'(PADDLE_HALF);
    localparam logic [COORD_W-1:0] PAD_MAX   = COORD_W'(SCREEN_H - 1 - PADDLE_HALF);

    localparam logic signed [COORD_W:0] PH_S = (COORD_W + 1)'(PADDLE_HALF);

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0]  TICK_ONE   = TICK_W'(1);
    localparam logic [SERVE_W-1:0] SERVE_LOAD = SERVE_W'(SERVE_DELAY - 1);
    localparam logic [SERVE_W-1:0] SERVE_ONE  = SERVE_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } phase_t;

    phase_t               phase;
    logic [TICK_W-1:0]    tick_cnt;
    logic [SERVE_W-1:0]   serve_cnt;
    logic [COORD_W-1:0]   ball_x, ball_y, left_pad, right_pad;
    logic                 vx_neg, vy_neg, serve_neg;
    logic [SCORE_W-1:0]   left_score, right_score;

    logic [COORD_W-1:0]   x_n, y_n, left_pad_n, right_pad_n;
    logic                 vx_neg_n, vy_neg_n, hit_left, hit_right;
    logic signed [COORD_W:0] diff_left, diff_right;
    logic [SCORE_W-1:0]   left_inc, right_inc;

    function automatic logic [COORD_W-1:0] paddle_next(
        input logic [COORD_W-1:0] pos,
        input logic               up,
        input logic               down
    );
        paddle_next = pos;
        if (up && !down && pos > PAD_MIN)
            paddle_next = pos - ONE;
        else if (down && !up && pos < PAD_MAX)
            paddle_next = pos + ONE;
    endfunction

    assign tick  = (tick_cnt == TICK_LAST);
    assign state = phase;

    always_comb begin
        left_pad_n  = paddle_next(left_pad, left_up, left_down);
        right_pad_n = paddle_next(right_pad, right_up, right_down);

        // One extra bit keeps the paddle distance signed without wrap.
        diff_left  = $signed({1'b0, ball_y}) - $signed({1'b0, left_pad});
        diff_right = $signed({1'b0, ball_y}) - $signed({1'b0, right_pad});
        hit_left   = (diff_left <= PH_S) && (diff_left >= -PH_S);
        hit_right  = (diff_right <= PH_S) && (diff_right >= -PH_S);

        vy_neg_n = vy_neg;
        if (ball_y == '0)
            vy_neg_n = 1'b0;
        else if (ball_y == Y_MAX)
            vy_neg_n = 1'b1;
        y_n = vy_neg_n ? (ball_y - ONE) : (ball_y + ONE);

        vx_neg_n = vx_neg;
        x_n      = vx_neg ? (ball_x - ONE) : (ball_x + ONE);
        if (ball_x == X_LHIT && vx_neg && hit_left) begin
            vx_neg_n = 1'b0;
            x_n      = X_LBOUNCE;
        end else if (ball_x == X_RHIT && !vx_neg && hit_right) begin
            vx_neg_n = 1'b1;
            x_n      = X_RBOUNCE;
        end

        left_inc  = (left_score == SCORE_WIN) ? left_score : left_score + SCORE_ONE;
        right_inc = (right_score == SCORE_WIN) ? right_score : right_score + SCORE_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TICK_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase       <= ST_IDLE;
            serve_cnt   <= '0;
            ball_x      <= X_MID;
            ball_y      <= Y_MID;
            vx_neg      <= 1'b0;
            vy_neg      <= 1'b0;
            serve_neg   <= 1'b0;
            left_pad    <= Y_MID;
            right_pad   <= Y_MID;
            left_score  <= '0;
            right_score <= '0;
            point_left  <= 1'b0;
            point_right <= 1'b0;
        end else begin
            point_left  <= 1'b0;
            point_right <= 1'b0;
            if (tick) begin
                if (phase != ST_OVER) begin
                    left_pad  <= left_pad_n;
                    right_pad <= right_pad_n;
                end
                case (phase)
                    ST_IDLE, ST_OVER: begin
                        if (start) begin
                            phase       <= ST_SERVE;
                            serve_cnt   <= SERVE_LOAD;
                            left_score  <= '0;
                            right_score <= '0;
                            serve_neg   <= 1'b0;
                        end
                    end
                    ST_SERVE: begin
                        ball_x <= X_MID;
                        ball_y <= Y_MID;
                        if (serve_cnt == '0) begin
                            phase  <= ST_PLAY;
                            vx_neg <= serve_neg;
                            vy_neg <= 1'b0;
                        end else begin
                            serve_cnt <= serve_cnt - SERVE_ONE;
                        end
                    end
                    ST_PLAY: begin
                        if (ball_x == '0) begin
                            right_score <= right_inc;
                            point_right <= 1'b1;
                            serve_neg   <= 1'b1;
                            ball_x      <= X_MID;
                            ball_y      <= Y_MID;
                            serve_cnt   <= SERVE_LOAD;
                            phase       <= (right_inc == SCORE_WIN) ? ST_OVER : ST_SERVE;
                        end else if (ball_x == X_MAX) begin
                            left_score  <= left_inc;
                            point_left  <= 1'b1;
                            serve_neg   <= 1'b0;
                            ball_x      <= X_MID;
                            ball_y      <= Y_MID;
                            serve_cnt   <= SERVE_LOAD;
                            phase       <= (left_inc == SCORE_WIN) ? ST_OVER : ST_SERVE;
                        end else begin
                            ball_x <= x_n;
                            ball_y <= y_n;
                            vx_neg <= vx_neg_n;
                            vy_neg <= vy_neg_n;
                        end
                    end
                    default: phase <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
        end else begin
            case (sel)
                3'd0:    data_out <= ball_x;
                3'd1:    data_out <= ball_y;
                3'd2:    data_out <= left_pad;
                3'd3:    data_out <= right_pad;
                3'd4:    data_out <= COORD_W'(left_score);
                3'd5:    data_out <= COORD_W'(right_score);
                3'd6:    data_out <= COORD_W'({serve_neg, phase});
                default: data_out <= '0;
            endcase
        end
    end

endmodule

// File: doc/pong_engine.md
Name: pong_engine

Overview:
- Parametrised successor to the single-screen pong datapath.
- Holds ball, paddles, scores and a game-phase FSM.
- Updates game state on a programmable frame tick, not every clock.
- Adds wall bounces, paddle-hit detection, scoring, serve delay and game-over, plus a registered readout mux for the tinytapeout top level.

Parameters:
COORD_W, 8, coordinate/output width; SCREEN_W and SCREEN_H ≤ 2^COORD_W
SCREEN_W, 160, playfield width in cells (x = 0..SCREEN_W-1)
SCREEN_H, 120, playfield height (y = 0..SCREEN_H-1; y = 0 is top)
PADDLE_HALF, 4, paddle half-extent; a hit needs |ball_y − paddle_y| ≤ PADDLE_HALF; must be < SCREEN_H/2
TICK_DIV, 4, clocks per game tick; ≥ 1
SERVE_DELAY, 16, ticks spent in SERVE before launch; ≥ 1
SCORE_W, 4, score counter width
WIN_SCORE, 9, score that ends the game; < 2^SCORE_W

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
left_up  input  1  move left paddle toward y = 0
left_down  input  1  move left paddle toward y = SCREEN_H-1
right_up  input  1  move right paddle up
right_down  input  1  move right paddle down
start  input  1  begin or restart a game; sampled on tick cycles only
sel  input  3  readout select
data_out  output  COORD_W  registered readout
tick  output  1  one-clock game-tick strobe
point_left  output  1  one-clock pulse: left player scored
point_right  output  1  one-clock pulse: right player scored
state  output  2  0 IDLE, 1 SERVE, 2 PLAY, 3 OVER

Behaviour:
Tick generation:
- Counter runs 0..TICK_DIV-1 and wraps; tick = 1 while the counter equals TICK_DIV-1.
- All game registers update only on clock edges where tick = 1. Only data_out updates every clock.

Reset values (next edge after reset = 1, including mid-game):
- ball_x = SCREEN_W/2, ball_y = SCREEN_H/2, vx = +1, vy = +1.
- Both paddles = SCREEN_H/2; both scores = 0; serve_dir = +1.
- state = IDLE; tick counter = 0; data_out = 0; point pulses = 0.

Paddles (every tick, states IDLE/SERVE/PLAY):
- Up only: decrement, unless already at PADDLE_HALF.
- Down only: increment, unless already at SCREEN_H-1-PADDLE_HALF.
- Both or neither: hold.
- In OVER: frozen.

FSM:
- IDLE: ball held at centre. start → SERVE; scores cleared; serve_dir = +1.
- SERVE: ball held at centre; serve counter counts ticks. After SERVE_DELAY ticks → PLAY with vx = serve_dir, vy = +1.
- PLAY, vertical (each tick):
  - vy_n = +1 if y == 0; −1 if y == SCREEN_H-1; else vy.
  - y_n = y + vy_n.
- PLAY, horizontal (each tick):
  - Paddle-hit test uses a (COORD_W+1)-bit signed difference.
  - Left paddle: x == 1, vx = −1 and |y − left_paddle| ≤ PADDLE_HALF → vx_n = +1, x_n = 2.
  - Right paddle: x == SCREEN_W-2, vx = +1 and hit → vx_n = −1, x_n = SCREEN_W-3.
  - Otherwise x_n = x + vx.
- PLAY, scoring:
  - x == 0 → right_score++, point_right pulses, serve_dir = −1 (serve toward the loser).
  - x == SCREEN_W-1 → left_score++, point_left pulses, serve_dir = +1.
  - After a point, the ball recentres and state → SERVE, or → OVER if the new score equals WIN_SCORE.
  - Horizontal and vertical updates apply independently on the same tick (corner cases are allowed).
- OVER: everything frozen. start → SERVE; scores cleared; serve_dir = +1.

Point pulses:
- Registered; high for exactly one clock, the clock after the scoring tick edge.
- Never both high at once.

Scores: saturate at WIN_SCORE and never wrap.

Readout:
- data_out updates every clock from sel; 1-clock latency.
- sel: 0 ball_x; 1 ball_y; 2 left_paddle; 3 right_paddle; 4 left_score; 5 right_score; 6 {serve_dir_neg, state}; 7 zero.
- All values zero-extended to COORD_W.

Test Plan:
- Reset with defaults, sel stepped 0..3 → data_out 80, 60, 60, 60; state = 0; tick high on every 4th clock.
- Pulse start on a tick → state 1. After 16 ticks → state 2. First PLAY tick → ball (81, 61).
- Let the ball travel to y = 119 → next tick y = 118 with vy = −1. Across 200 ticks, y stays in 0..119.
- Right paddle driven to track ball_y → ball at x = 158 reflects to x = 157; no point pulse; scores unchanged.
- Hold left_up until the left paddle clamps at 4; ball arrives at the left edge away from it → right score 1, point_right high for 1 clock, state 1, next launch vx = −1. Holding both left_up and left_down → paddle unchanged.
- WIN_SCORE = 2: two misses → state 3, ball and paddles frozen; start → state 1, scores 0. Assert reset mid-PLAY → all reset values on the next edge.
